// File: rtl/multi_cycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle control FSM and its datapath.
// Optional PERF_CNT_EN adds the cycles/stalls performance counter outputs.
interface multi_cycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctr;
    logic [1:0]       pc_source;

    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] stalls;
`endif

    // Datapath / sequencer side: drives instruction fields and handshakes, observes controls.
    modport master (
        output run, opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctr,
               pc_source, state, illegal, retired
`ifdef PERF_CNT_EN
        , input cycles, stalls
`endif
    );

    // Control FSM side.
    modport slave (
        input  run, opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctr,
               pc_source, state, illegal, retired
`ifdef PERF_CNT_EN
        , output cycles, stalls
`endif
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback sequencing,
// handshaked memory with timeout trap, illegal-opcode trap and retired-instruction counter.
// Optional feature macro: PERF_CNT_EN (cycles and stalls counters).
//
// state | meaning
// IDLE  | parked, all controls low, waits for run
// IF    | instruction fetch, waits for mem_ready, PC += 4
// ID    | decode, branch target into ALUOut
// EX    | ALU operation / branch / jump
// MEMA  | data memory access, waits for mem_ready
// WB    | register file write
// TRAP  | illegal opcode or memory timeout, sticky until reset
module multi_cycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int MEM_TMO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_cycle_ctrl_if.slave bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_IF   = 4'd1;
    localparam logic [3:0] S_ID   = 4'd2;
    localparam logic [3:0] S_EX   = 4'd3;
    localparam logic [3:0] S_MEMA = 4'd4;
    localparam logic [3:0] S_WB   = 4'd5;
    localparam logic [3:0] S_TRAP = 4'd6;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Down-counter holds remaining not-ready cycles before the timeout fires.
    localparam int              TMR_W    = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
    localparam logic [TMR_W-1:0] TMR_INIT = (MEM_TMO > 0) ? TMR_W'(MEM_TMO - 1) : '0;

    logic [3:0]       state_q, state_nxt;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             tmo_hit;
    logic             is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_ori;
    logic             funct_ok;
    logic [2:0]       r_alu;
    logic [3:0]       boundary;

    assign is_r    = (bus.opcode == OP_R);
    assign is_lw   = (bus.opcode == OP_LW);
    assign is_sw   = (bus.opcode == OP_SW);
    assign is_beq  = (bus.opcode == OP_BEQ);
    assign is_j    = (bus.opcode == OP_J);
    assign is_addi = (bus.opcode == OP_ADDI);
    assign is_ori  = (bus.opcode == OP_ORI);

    assign tmo_hit  = (MEM_TMO != 0) && (tmr_q == '0);
    assign boundary = bus.run ? S_IF : S_IDLE;

    // R-type funct decode to ALU operation and legality.
    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_ADD;
        case (bus.funct)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h2A:   r_alu = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state and retire decision.
    always_comb begin
        state_nxt = state_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.run) state_nxt = S_IF;
            S_IF: begin
                if (bus.mem_ready)  state_nxt = S_ID;
                else if (tmo_hit)   state_nxt = S_TRAP;
            end
            S_ID: begin
                if ((is_r && funct_ok) || is_lw || is_sw || is_beq || is_j || is_addi || is_ori)
                    state_nxt = S_EX;
                else
                    state_nxt = S_TRAP;
            end
            S_EX: begin
                if (is_beq || is_j) begin
                    retire    = 1'b1;
                    state_nxt = boundary;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEMA;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEMA: begin
                if (bus.mem_ready) begin
                    if (is_lw) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = boundary;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                retire    = 1'b1;
                state_nxt = boundary;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, wait timer and retired counter; the timer reloads on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_nxt != state_q)
                tmr_q <= TMR_INIT;
            else if (tmr_q != '0)
                tmr_q <= tmr_q - 1'b1;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Moore control decode; forced low while reset is asserted so no write commits.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_ctr       = ALU_AND;
        bus.pc_source     = 2'd0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write  = 1'b1;
                        bus.alu_src_b = 2'd1;
                        bus.alu_ctr   = ALU_ADD;
                        bus.pc_write  = 1'b1;
                    end
                end
                S_ID: begin
                    bus.alu_src_b = 2'd3;
                    bus.alu_ctr   = ALU_ADD;
                end
                S_EX: begin
                    if (is_r) begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_ctr   = r_alu;
                    end else if (is_lw || is_sw || is_addi) begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'd2;
                        bus.alu_ctr   = ALU_ADD;
                    end else if (is_ori) begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'd2;
                        bus.alu_ctr   = ALU_OR;
                    end else if (is_beq) begin
                        bus.alu_src_a     = 1'b1;
                        bus.alu_ctr       = ALU_SUB;
                        bus.pc_write_cond = 1'b1;
                        bus.pc_source     = 2'd1;
                    end else if (is_j) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 2'd2;
                    end
                end
                S_MEMA: begin
                    bus.iord      = 1'b1;
                    bus.mem_read  = is_lw;
                    bus.mem_write = is_sw;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = is_r;
                    bus.mem_to_reg = is_lw;
                end
                default: ;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = (state_q == S_TRAP);
    assign bus.retired = retired_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycles_q, stalls_q;

    // Active-cycle and memory-stall counters, frozen in IDLE and TRAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles_q <= '0;
            stalls_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP)
                cycles_q <= cycles_q + CNT_W'(1);
            if ((state_q == S_IF || state_q == S_MEMA) && !bus.mem_ready)
                stalls_q <= stalls_q + CNT_W'(1);
        end
    end

    assign bus.cycles = cycles_q;
    assign bus.stalls = stalls_q;
`endif
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: sequencing, memory stalls, branches, traps, timeout.
module tb_multi_cycle_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multi_cycle_ctrl_if #(.CNT_W(32)) bus ();

    multi_cycle_ctrl #(.CNT_W(32), .MEM_TMO(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] ctrl_vec();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_ctr, bus.pc_source};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h20;
        bus.zero      = 1'b0;

        // reset held three cycles
        tick(); tick(); tick();
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_ctrl", 64'(ctrl_vec()), 64'd0);
        chk("rst_retired", 64'(bus.retired), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        rst_n = 1'b1;

        // add: IF ID EX WB
        tick();
        chk("add_if_state", 64'(bus.state), 64'd1);
        chk("add_if_irw", 64'(bus.ir_write), 64'd1);
        chk("add_if_pcw", 64'(bus.pc_write), 64'd1);
        chk("add_if_srcb", 64'(bus.alu_src_b), 64'd1);
        chk("add_if_iord", 64'(bus.iord), 64'd0);
        tick();
        chk("add_id_state", 64'(bus.state), 64'd2);
        chk("add_id_srcb", 64'(bus.alu_src_b), 64'd3);
        chk("add_id_regw", 64'(bus.reg_write), 64'd0);
        tick();
        chk("add_ex_state", 64'(bus.state), 64'd3);
        chk("add_ex_srca", 64'(bus.alu_src_a), 64'd1);
        chk("add_ex_alu", 64'(bus.alu_ctr), 64'b010);
        chk("add_ex_regw", 64'(bus.reg_write), 64'd0);
        tick();
        chk("add_wb_state", 64'(bus.state), 64'd5);
        chk("add_wb_regw", 64'(bus.reg_write), 64'd1);
        chk("add_wb_regdst", 64'(bus.reg_dst), 64'd1);
        chk("add_wb_retired", 64'(bus.retired), 64'd0);
        tick();
        chk("add_done_state", 64'(bus.state), 64'd1);
        chk("add_done_retired", 64'(bus.retired), 64'd1);

        // lw with three stall cycles in MEMA
        bus.opcode = 6'h23;
        tick();
        chk("lw_id_state", 64'(bus.state), 64'd2);
        tick();
        chk("lw_ex_srcb", 64'(bus.alu_src_b), 64'd2);
        chk("lw_ex_alu", 64'(bus.alu_ctr), 64'b010);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("lw_mem1_state", 64'(bus.state), 64'd4);
        chk("lw_mem1_rd", 64'({bus.mem_read, bus.iord, bus.mem_write}), 64'b110);
        tick();
        chk("lw_mem2_state", 64'(bus.state), 64'd4);
        tick();
        chk("lw_mem3_rd", 64'({bus.mem_read, bus.iord}), 64'b11);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_mem4_state", 64'(bus.state), 64'd4);
        chk("lw_mem4_rd", 64'({bus.mem_read, bus.iord}), 64'b11);
        tick();
        chk("lw_wb_state", 64'(bus.state), 64'd5);
        chk("lw_wb_m2r", 64'({bus.mem_to_reg, bus.reg_write, bus.reg_dst}), 64'b110);
`ifdef PERF_CNT_EN
        chk("lw_stalls", 64'(bus.stalls), 64'd3);
`endif
        tick();
        chk("lw_done_retired", 64'(bus.retired), 64'd2);

        // beq taken then not taken
        bus.opcode = 6'h04;
        bus.zero   = 1'b1;
        tick(); tick();
        chk("beq1_ex_state", 64'(bus.state), 64'd3);
        chk("beq1_ex_ctl", 64'({bus.pc_write_cond, bus.pc_source, bus.alu_ctr, bus.pc_write}), 64'b1_01_110_0);
        tick();
        chk("beq1_state", 64'(bus.state), 64'd1);
        chk("beq1_retired", 64'(bus.retired), 64'd3);
        bus.zero = 1'b0;
        tick(); tick();
        chk("beq0_ex_ctl", 64'({bus.pc_write_cond, bus.pc_source}), 64'b1_01);
        tick();
        chk("beq0_retired", 64'(bus.retired), 64'd4);

        // j
        bus.opcode = 6'h02;
        tick(); tick();
        chk("j_ex_ctl", 64'({bus.pc_write, bus.pc_source, bus.pc_write_cond}), 64'b1_10_0);
        tick();
        chk("j_retired", 64'(bus.retired), 64'd5);

        // ori: zero-extended immediate, OR operation, rt destination
        bus.opcode = 6'h0D;
        tick(); tick();
        chk("ori_ex_ctl", 64'({bus.alu_src_a, bus.alu_src_b, bus.alu_ctr}), 64'b1_10_001);
        tick();
        chk("ori_wb_ctl", 64'({bus.reg_write, bus.reg_dst, bus.mem_to_reg}), 64'b100);
        tick();
        chk("ori_retired", 64'(bus.retired), 64'd6);

        // sw with run dropped mid-instruction: finishes, then parks
        bus.opcode = 6'h2B;
        tick();
        bus.run = 1'b0;
        tick();
        chk("sw_ex_state", 64'(bus.state), 64'd3);
        tick();
        chk("sw_mem_ctl", 64'({bus.mem_write, bus.mem_read, bus.iord}), 64'b101);
        tick();
        chk("sw_idle_state", 64'(bus.state), 64'd0);
        chk("sw_retired", 64'(bus.retired), 64'd7);
        tick();
        chk("idle_hold", 64'(bus.state), 64'd0);
        bus.run = 1'b1;
        tick();
        chk("idle_to_if", 64'(bus.state), 64'd1);

        // illegal opcode trap, run ignored, reset clears
        bus.opcode = 6'h3F;
        tick();
        chk("ill_id_state", 64'(bus.state), 64'd2);
        tick();
        chk("ill_trap_state", 64'(bus.state), 64'd6);
        chk("ill_flag", 64'(bus.illegal), 64'd1);
        chk("ill_retired", 64'(bus.retired), 64'd7);
        bus.run = 1'b0;
        tick();
        bus.run = 1'b1;
        tick();
        chk("ill_stuck", 64'(bus.state), 64'd6);
        chk("ill_ctrl", 64'(ctrl_vec()), 64'd0);
        rst_n = 1'b0;
        tick();
        chk("ill_rst_state", 64'(bus.state), 64'd0);
        chk("ill_rst_flag", 64'(bus.illegal), 64'd0);
        chk("ill_rst_retired", 64'(bus.retired), 64'd0);

        // R-type with unknown funct traps in ID
        bus.opcode = 6'h00;
        bus.funct  = 6'h21;
        rst_n      = 1'b1;
        tick(); tick(); tick();
        chk("badfn_trap", 64'(bus.state), 64'd6);

        // ready on the 15th waiting cycle still counts as success
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.funct     = 6'h20;
        tick();
        for (int i = 0; i < 13; i++) tick();
        chk("tmo14_state", 64'(bus.state), 64'd1);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        tick();
        chk("tmo_ready_wins", 64'(bus.state), 64'd2);

        // mem_ready stuck low in IF: trap after 15 cycles, no IR write
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo_wait_state", 64'(bus.state), 64'd1);
            chk("tmo_wait_irw", 64'(bus.ir_write), 64'd0);
        end
        tick();
        chk("tmo_trap_state", 64'(bus.state), 64'd6);
        chk("tmo_trap_flag", 64'(bus.illegal), 64'd1);
        chk("tmo_trap_ctrl", 64'(ctrl_vec()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
